// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 binary mux tree (N = 2**SEL_W) with valid/ready flow control, select tagging and auto-scan.
// Defining MUX_TREE_PARITY_EN adds the out_par port (even parity of out_data, aligned with it).
module mux_tree_pipe #(
  parameter int DATA_W = 1,
  parameter int SEL_W  = 4,
  parameter int PIPE   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [(DATA_W<<SEL_W)-1:0] in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       mode,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       out_valid,
  input  logic                       out_ready
`ifdef MUX_TREE_PARITY_EN
  ,
  output logic                       out_par
`endif
);

  localparam int N = 1 << SEL_W;

  logic             adv;
  logic             accept;
  logic             mode_prev_reg;
  logic [SEL_W-1:0] scan_idx_reg;
  logic [SEL_W-1:0] scan_base;
  logic [SEL_W-1:0] esel;
  logic [DATA_W-1:0] out_data_reg;
  logic [SEL_W-1:0]  out_sel_reg;
  logic              out_valid_reg;

  // One global stall: every stage advances together or holds together.
  assign adv      = out_ready | ~out_valid_reg;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  // First cycle of auto-scan restarts the scan at channel 0.
  assign scan_base = (mode & ~mode_prev_reg) ? '0 : scan_idx_reg;
  assign esel      = mode ? scan_base : sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_prev_reg <= 1'b0;
      scan_idx_reg  <= '0;
    end else begin
      mode_prev_reg <= mode;
      if (mode) begin
        scan_idx_reg <= accept ? scan_base + 1'b1 : scan_base;
      end
    end
  end

  // Level gi halves the candidate set using select bit gi; the full tag rides alongside.
  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_lvl
    localparam int IW = (N >> gi) * DATA_W;
    localparam int OW = IW / 2;

    logic [IW-1:0]    src_data;
    logic [SEL_W-1:0] tag_in;
    logic             valid_in;
    logic [OW-1:0]    mux_data;
    logic [OW-1:0]    lvl_out;
    logic [SEL_W-1:0] tag_out;
    logic             valid_out;

    if (gi == 0) begin : g_src
      assign src_data = in_data;
      assign tag_in   = esel;
      assign valid_in = accept;
    end else begin : g_src
      assign src_data = g_lvl[gi-1].lvl_out;
      assign tag_in   = g_lvl[gi-1].tag_out;
      assign valid_in = g_lvl[gi-1].valid_out;
    end

    for (genvar gj = 0; gj < (N >> (gi + 1)); gj++) begin : g_mux
      assign mux_data[gj*DATA_W +: DATA_W] = tag_in[gi] ?
        src_data[(2*gj+1)*DATA_W +: DATA_W] : src_data[(2*gj)*DATA_W +: DATA_W];
    end

    // The last level feeds the shared output register, so it never gets its own stage.
    if (PIPE != 0 && gi < SEL_W - 1) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lvl_out   <= '0;
          tag_out   <= '0;
          valid_out <= 1'b0;
        end else if (adv) begin
          lvl_out   <= mux_data;
          tag_out   <= tag_in;
          valid_out <= valid_in;
        end
      end
    end else begin : g_wire
      assign lvl_out   = mux_data;
      assign tag_out   = tag_in;
      assign valid_out = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (adv) begin
      out_data_reg  <= g_lvl[SEL_W-1].lvl_out;
      out_sel_reg   <= g_lvl[SEL_W-1].tag_out;
      out_valid_reg <= g_lvl[SEL_W-1].valid_out;
    end
  end

  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;
  assign out_valid = out_valid_reg;

`ifdef MUX_TREE_PARITY_EN
  logic out_par_reg;

  // Parity is computed from the same value loaded into out_data_reg, so it can never skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_par_reg <= 1'b0;
    end else if (adv) begin
      out_par_reg <= ^g_lvl[SEL_W-1].lvl_out;
    end
  end

  assign out_par = out_par_reg;
`else
  // Parity disabled: no parity state exists in this build.
`endif

endmodule
